// File: rtl/crc_serial_appender_pkg.sv
// Shared state encoding and width helper for the serial CRC appender.
package crc_serial_appender_pkg;

  typedef enum logic [1:0] {
    ST_PASS   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_APPEND = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_shift_out.sv
// Loadable CRC shift register with down-counter; LSB_FIRST selects shift direction.
module crc_shift_out
  import crc_serial_appender_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_first_bit,
  output logic             o_next_bit,
  output logic             o_done
);

  localparam int CNT_W = clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_shift_val;

  // The first bit leaves directly from i_data, so the register holds only the remainder.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign o_first_bit = i_data[0];
      assign o_next_bit  = r_shift[0];
      assign w_load_val  = i_data >> 1;
      assign w_shift_val = r_shift >> 1;
    end else begin : g_msb
      assign o_first_bit = i_data[WIDTH-1];
      assign o_next_bit  = r_shift[WIDTH-1];
      assign w_load_val  = i_data << 1;
      assign w_shift_val = r_shift << 1;
    end
  endgenerate

  assign o_done = (r_count == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_shift <= w_load_val;
      r_count <= CNT_W'(WIDTH - 1);
    end else if (i_shift) begin
      r_shift <= w_shift_val;
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/crc_serial_appender.sv
// Forwards serial frame data one cycle late, then appends the generator's CRC serially.
// Optional macro CRC_APPEND_LSB_FIRST_EN sends the CRC LSB first (default MSB first).
module crc_serial_appender
  import crc_serial_appender_pkg::*;
#(
  parameter int CRC_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  input  logic                enable_in,
  input  logic                last_in,
  input  logic [CRC_SIZE-1:0] crc_in,
  output logic                serial_out,
  output logic                enable_out,
  output logic                last_out,
  output logic                busy,
  output logic                overrun
);

`ifdef CRC_APPEND_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  state_t r_state;
  state_t w_state_next;
  logic   r_serial, w_serial_next;
  logic   r_enable, w_enable_next;
  logic   r_last, w_last_next;
  logic   r_overrun;
  logic   w_load, w_shift;
  logic   w_first_bit, w_next_bit, w_done;

  crc_shift_out #(
    .WIDTH    (CRC_SIZE),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift_out (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (crc_in),
    .o_first_bit(w_first_bit),
    .o_next_bit (w_next_bit),
    .o_done     (w_done)
  );

  always_comb begin
    w_state_next  = r_state;
    w_serial_next = r_serial;
    w_enable_next = r_enable;
    w_last_next   = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    case (r_state)
      ST_PASS: begin
        w_serial_next = serial_in;
        w_enable_next = enable_in;
        if (enable_in && last_in) w_state_next = ST_LATCH;
      end
      // crc_in is final only now, one cycle after the last bit reached the generator.
      ST_LATCH: begin
        w_serial_next = w_first_bit;
        w_enable_next = 1'b1;
        w_load        = 1'b1;
        w_state_next  = ST_APPEND;
      end
      ST_APPEND: begin
        w_serial_next = w_next_bit;
        w_enable_next = 1'b1;
        w_shift       = 1'b1;
        if (w_done) begin
          w_last_next  = 1'b1;
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_serial_next = 1'b0;
        w_enable_next = 1'b0;
        w_state_next  = ST_PASS;
      end
      default: w_state_next = ST_PASS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_PASS;
      r_serial  <= 1'b0;
      r_enable  <= 1'b0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_serial <= w_serial_next;
      r_enable <= w_enable_next;
      r_last   <= w_last_next;
      if (busy && enable_in) r_overrun <= 1'b1;
    end
  end

  assign busy       = (r_state != ST_PASS);
  assign serial_out = r_serial;
  assign enable_out = r_enable;
  assign last_out   = r_last;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_crc_serial_appender.sv
// Scoreboard bench for crc_serial_appender with CRC_SIZE=8.
module tb_crc_serial_appender;

  localparam int CRC_SIZE = 8;

  logic                clk;
  logic                rst;
  logic                serial_in;
  logic                enable_in;
  logic                last_in;
  logic [CRC_SIZE-1:0] crc_in;
  logic                serial_out;
  logic                enable_out;
  logic                last_out;
  logic                busy;
  logic                overrun;

  int total;
  int bad;
  logic [1:0] sb[$];  // {serial, last} per enabled output cycle

  crc_serial_appender #(.CRC_SIZE(CRC_SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .enable_in (enable_in),
    .last_in   (last_in),
    .crc_in    (crc_in),
    .serial_out(serial_out),
    .enable_out(enable_out),
    .last_out  (last_out),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: every enabled output bit must match the next scoreboard entry.
  always @(negedge clk) begin
    logic [1:0] exp;
    if (rst === 1'b0) begin
      if (enable_out !== 1'b0) begin
        total = total + 1;
        if (sb.size() == 0) begin
          bad = bad + 1;
          $display("FAIL out_unexpected: got serial=%b last=%b, required no output", serial_out, last_out);
        end else begin
          exp = sb.pop_front();
          if ({serial_out, last_out} !== exp)begin
            bad = bad + 1;
            $display("FAIL out_bit: got serial=%b last=%b, required serial=%b last=%b",
                     serial_out, last_out, exp[1], exp[0]);
          end else begin
            $display("out bit serial=%b last=%b", serial_out, last_out);
          end
        end
      end else if (last_out !== 1'b0) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL last_idle: got last_out=%b, required 0", last_out);
      end
    end
  end

  function automatic int crc_index(input int j);
`ifdef CRC_APPEND_LSB_FIRST_EN
    return j;
`else
    return CRC_SIZE - 1 - j;
`endif
  endfunction

  // Drives bits[i] with enable ens[i]; last_in on final cycle and on gap cycles (must be ignored).
  task automatic send_frame(input logic [63:0] bits, input logic [63:0] ens, input int n,
                            input logic [CRC_SIZE-1:0] crc, input int ovr_at);
    int busy_cnt;
    int guard;
    for (int i = 0; i < n; i++) begin
      serial_in = bits[i];
      enable_in = ens[i];
      last_in   = (i == n - 1) || !ens[i];
      crc_in    = ~crc;
      if (ens[i]) sb.push_back({bits[i], 1'b0});
      @(negedge clk);
    end
    enable_in = 1'b0;
    last_in   = 1'b0;
    serial_in = 1'b0;
    crc_in    = crc;
    for (int j = 0; j < CRC_SIZE; j++) sb.push_back({crc[crc_index(j)], (j == CRC_SIZE - 1)});
    busy_cnt = 0;
    guard    = 0;
    while (busy === 1'b1 && guard < 40) begin
      busy_cnt = busy_cnt + 1;
      guard    = guard + 1;
      @(negedge clk);
      crc_in    = ~crc;
      enable_in = (busy_cnt == ovr_at);
      serial_in = enable_in;
      last_in   = enable_in;
    end
    enable_in = 1'b0;
    serial_in = 1'b0;
    last_in   = 1'b0;
    total = total + 1;
    if (busy_cnt !== CRC_SIZE + 1) begin
      bad = bad + 1;
      $display("FAIL busy_len: got %0d cycles, required %0d", busy_cnt, CRC_SIZE + 1);
    end else begin
      $display("frame n=%0d crc=%h busy=%0d cycles", n, crc, busy_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serial_in = 1'b0;
    enable_in = 1'b0;
    last_in = 1'b0;
    crc_in = '0;
    repeat (3) @(negedge clk);
    total = total + 1;
    if ({serial_out, enable_out, last_out, busy, overrun} !== 5'b0) begin
      bad = bad + 1;
      $display("FAIL reset_vals: got %b, required 00000",
               {serial_out, enable_out, last_out, busy, overrun});
    end else $display("reset outputs ok");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(64'b1101, 64'b1111, 4, 8'hA5, -1);
  endtask

  task automatic test_back_to_back();
    send_frame(64'b1, 64'b1, 1, 8'h3C, -1);
    send_frame(64'b0110, 64'b1111, 4, 8'h5A, -1);
  endtask

  task automatic test_gaps();
    send_frame(64'b110, 64'b101, 3, 8'h81, -1);
  endtask

  task automatic test_overrun();
    total = total + 1;
    if (overrun !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL overrun_pre: got %b, required 0", overrun);
    end
    send_frame(64'b1011, 64'b1111, 4, 8'hC3, 3);
    total = total + 1;
    if (overrun !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end else $display("overrun set");
    send_frame(64'b01, 64'b11, 2, 8'h17, -1);
    total = total + 1;
    if (overrun !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end else $display("overrun sticky");
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits;
    bits = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      serial_in = bits[i];
      enable_in = 1'b1;
      last_in   = (i == 3);
      crc_in    = 8'h69;
      sb.push_back({bits[i], 1'b0});
      @(negedge clk);
    end
    enable_in = 1'b0;
    last_in   = 1'b0;
    serial_in = 1'b0;
    crc_in    = 8'h96;
    for (int j = 0; j < CRC_SIZE; j++) sb.push_back({crc_in[crc_index(j)], (j == CRC_SIZE - 1)});
    repeat (3) @(negedge clk);  // now in the 3rd APPEND cycle
    #2 rst = 1'b1;
    #1;
    total = total + 1;
    if ({serial_out, enable_out, last_out, busy, overrun} !== 5'b0) begin
      bad = bad + 1;
      $display("FAIL reset_mid: got %b, required 00000",
               {serial_out, enable_out, last_out, busy, overrun});
    end else $display("mid-append reset ok");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(64'b0011, 64'b1111, 4, 8'hE7, -1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_overrun();
    test_reset_mid();
    repeat (4) @(negedge clk);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL sb_drain: got %0d pending bits, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_serial_appender.md
Name: crc_serial_appender

Overview:
- Sits directly downstream of the serial CRC generators (crc_static / crc_dynamic), on the same serial/enable stream that feeds them.
- Forwards each frame's data bits with one cycle of latency.
- After the frame's last bit, captures the generator's final CRC and shifts it out serially, contiguous with the data.
- Produces a complete data+CRC bitstream for transmission or loop-back checking.

Parameters:
- CRC_SIZE, 32, width of the CRC word in bits; legal range 4 to 64.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- serial_in  input  1  data bit; valid when enable_in=1.
- enable_in  input  1  bit-valid strobe; the same strobe drives the CRC generator.
- last_in  input  1  marks the final data bit of a frame; sampled only when enable_in=1.
- crc_in  input  CRC_SIZE  CRC generator output; valid the cycle after the last bit is clocked.
- serial_out  output  1  outgoing bit (data, then CRC).
- enable_out  output  1  serial_out valid.
- last_out  output  1  high with the final CRC bit of the frame.
- busy  output  1  high while capturing or appending; upstream must hold enable_in low.
- overrun  output  1  sticky error: enable_in seen while busy; cleared only by rst.

Behaviour:
- Reset values: serial_out=0, enable_out=0, last_out=0, busy=0, overrun=0, state=PASS, shift register=0, bit counter=0.
- All outputs are registered; busy is decoded from state.
- State PASS:
  - Each edge: serial_out<=serial_in, enable_out<=enable_in, last_out<=0. Gaps in enable_in pass through unchanged.
  - On an edge with enable_in=1 and last_in=1: go to LATCH.
  - last_in with enable_in=0 is ignored.
- State LATCH, exactly one cycle:
  - crc_in is final during this cycle, because the generator registers the last bit on the previous edge.
  - The output still shows the last data bit (enable_out=1).
  - At the edge: serial_out<=crc_in[CRC_SIZE-1], enable_out<=1, shift register<=crc_in<<1, counter<=CRC_SIZE-1, go to APPEND.
- State APPEND:
  - Each edge: serial_out<=shift register MSB, shift register<<=1, counter decrements, enable_out<=1.
  - On the edge where counter=1: also last_out<=1, go to DRAIN.
- State DRAIN, one cycle:
  - The output shows the final CRC bit with last_out=1.
  - At the edge: enable_out<=0, last_out<=0, go to PASS.
- Timing: with the last data bit at input cycle T, CRC bits occupy output cycles T+2 through T+1+CRC_SIZE with no gap. Total latency from last_in to last_out is CRC_SIZE+1 cycles.
- busy=1 in LATCH, APPEND and DRAIN. Any enable_in=1 during busy sets overrun; that bit is dropped and never forwarded. last_in during busy is ignored.
- A single-bit frame (enable_in and last_in in the same first cycle) is legal and goes straight to LATCH.
- A new frame may start in the cycle right after DRAIN (state is PASS again).
- rst mid-frame or mid-append:
  - Immediate return to reset values; a partial CRC is never completed.
  - Re-initialising the CRC generator is the system's job; both blocks share rst.

Optional Feature:
- Macro CRC_APPEND_LSB_FIRST_EN.
- Defined: the CRC is transmitted LSB first. In LATCH, serial_out<=crc_in[0] and the shift register shifts right; the shift register is otherwise unchanged.
- Undefined (default): MSB first, as described above.
- Data bits are never reordered in either mode.

Decomposition:
- Shared header crc_defs.vh holds the state encodings (PASS=2'd0, LATCH=2'd1, APPEND=2'd2, DRAIN=2'd3) and the counter-width function clog2(CRC_SIZE+1).
- One natural sub-module: crc_shift_out, a loadable CRC_SIZE-bit shift register with a down-counter and a done flag, parameterised on shift direction. The top level keeps the FSM and the pass-through register.

Test Plan:
- CRC_SIZE=8; bits 1,0,1,1 with last_in on the 4th; bench drives crc_in=8'hA5 in LATCH -> serial_out 1,0,1,1,1,0,1,0,0,1,0,1 on contiguous enable_out cycles; last_out only on the 12th; busy high for 9 cycles.
- Same stimulus with CRC_APPEND_LSB_FIRST_EN defined -> CRC portion 1,0,1,0,0,1,0,1 (8'hA5 LSB first); data portion unchanged.
- Full chain with CRC_SIZE=32: parallel_to_serial loads 128'h73713cb13141af131d313d3231398810, crc_static (init 0, poly 04C11DB7, xor FFFFFFFF) generates, last_in asserted on bit 128 -> 160 output bits; the last 32 equal the crc_s value latched one cycle after bit 128.
- Input bit 0,1 with gaps (enable_in 1,0,1) -> enable_out 1,0,1 one cycle later; serial_out values unchanged.
- enable_in=1 during APPEND -> overrun=1 and stays 1; CRC sequence unaffected and the bit is never forwarded.
- rst pulsed in the 3rd APPEND cycle -> all outputs 0 in the same cycle; next frame after rst passes through normally.
